// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory bus arbiter.
//   mst_id_t    : owner id recorded per accepted transaction (0 = I fetch, 1 = D / MEM stage)
//   arb_state_t : arbiter grant state (free arbitration or locked to one master)
//   lock_of()   : lock state that holds a grant for the given master
package mem_arb_pkg;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mst_id_t;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  function automatic arb_state_t lock_of(input mst_id_t id);
    return (id == MST_D) ? LOCK_D : LOCK_I;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers which master owns each accepted, not yet returned
// transaction so in-order responses can be steered back.
//   clk, rst      : clock, asynchronous active-low reset
//   push, push_id : record a new owner id (ignored when full)
//   pop           : retire the head entry (ignored when empty)
//   head_id       : owner of the oldest outstanding transaction
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_id,
  input  logic                       pop,
  output logic                       head_id,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_id = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (I fetch, D / MEM stage) in front of one sram-like
// req/addr_ok/data_ok port. D has priority; a stalled grant is held until
// accepted or withdrawn. Responses return in order and are steered to the
// owner recorded at accept time.
//   clk, rst          : clock, asynchronous active-low reset
//   i_* / d_*         : master request fields in, addr_ok/data_ok/rdata out
//   bus_*             : downstream request out, addr_ok/data_ok/rdata in
//   outstanding       : accepted-but-unreturned transactions
//   arb_err           : sticky, data_ok arrived with nothing outstanding
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic                     i_wr,
  input  logic                     i_cached,
  input  logic [1:0]               i_size,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [3:0]               i_wstrb,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic                     i_addr_ok,
  output logic                     i_data_ok,
  output logic [DATA_W-1:0]        i_rdata,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic                     d_cached,
  input  logic [1:0]               d_size,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [3:0]               d_wstrb,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_addr_ok,
  output logic                     d_data_ok,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     bus_req,
  output logic                     bus_wr,
  output logic                     bus_cached,
  output logic [1:0]               bus_size,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [3:0]               bus_wstrb,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic                     bus_addr_ok,
  input  logic                     bus_data_ok,
  input  logic [DATA_W-1:0]        bus_rdata,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     arb_err
);

  arb_state_t state;
  arb_state_t state_nxt;
  mst_id_t    gnt_id;
  logic       gnt_vld;
  logic       full;
  logic       empty;
  logic       head_raw;
  logic       accept;
  logic       bypass;
  logic       push;
  logic       pop;
  logic       resp_vld;
  mst_id_t    resp_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= state_nxt;
  end

  // Grant selection. A lock whose master withdrew falls through to a fresh
  // arbitration in the same cycle, so the other master can win immediately.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = MST_I;
    unique case (state)
      LOCK_D: begin
        if (d_req) begin
          gnt_vld = 1'b1;
          gnt_id  = MST_D;
        end else if (i_req) begin
          gnt_vld = 1'b1;
          gnt_id  = MST_I;
        end
      end
      LOCK_I: begin
        if (i_req) begin
          gnt_vld = 1'b1;
          gnt_id  = MST_I;
        end else if (d_req) begin
          gnt_vld = 1'b1;
          gnt_id  = MST_D;
        end
      end
      default: begin
        if (d_req) begin
          gnt_vld = 1'b1;
          gnt_id  = MST_D;
        end else if (i_req) begin
          gnt_vld = 1'b1;
          gnt_id  = MST_I;
        end
      end
    endcase
  end

  // rst gates the handshakes so they drop the instant reset asserts.
  assign bus_req = rst && gnt_vld && !full;
  assign accept  = bus_req && bus_addr_ok;

  always_comb begin
    state_nxt = ARB;
    if (gnt_vld && !accept) state_nxt = lock_of(gnt_id);
  end

  always_comb begin
    bus_wr     = i_wr;
    bus_cached = i_cached;
    bus_size   = i_size;
    bus_addr   = i_addr;
    bus_wstrb  = i_wstrb;
    bus_wdata  = i_wdata;
    if (gnt_id == MST_D) begin
      bus_wr     = d_wr;
      bus_cached = d_cached;
      bus_size   = d_size;
      bus_addr   = d_addr;
      bus_wstrb  = d_wstrb;
      bus_wdata  = d_wdata;
    end
  end

  assign i_addr_ok = accept && (gnt_id == MST_I);
  assign d_addr_ok = accept && (gnt_id == MST_D);

  // An accept and its data_ok in the same cycle with nothing queued is a
  // zero-latency transaction: route it to the grant and skip the FIFO.
  assign bypass   = empty && accept && bus_data_ok;
  assign push     = accept && !bypass;
  assign pop      = bus_data_ok && !empty;
  assign resp_vld = rst && bus_data_ok && (!empty || accept);
  assign resp_id  = empty ? gnt_id : mst_id_t'(head_raw);

  assign i_data_ok = resp_vld && (resp_id == MST_I);
  assign d_data_ok = resp_vld && (resp_id == MST_D);
  assign i_rdata   = bus_rdata;
  assign d_rdata   = bus_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  arb_err <= 1'b0;
    else if (bus_data_ok && empty && !accept)  arb_err <= 1'b1;
  end

  arb_owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (gnt_id == MST_D),
    .pop     (pop),
    .head_id (head_raw),
    .full    (full),
    .empty   (empty),
    .count   (outstanding)
  );

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing one sram-like request/addr_ok/data_ok port toward the cache/AXI bridge. Masters are instruction fetch (I) and the MEM stage (D).
- Grants one request per cycle, holds a grant across a stalled address handshake, and records the owner of each accepted transaction. In-order data_ok/rdata are steered back to the owning master.
- Sits between the pipeline front/MEM stages and the cache layer.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_OUT, 2, outstanding accepted-but-unreturned transactions (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- i_req, i_wr, i_cached  in  1 each  I request, write flag, cacheable flag.
- i_size  in  2  I access size.
- i_addr  in  ADDR_W  I address.
- i_wstrb  in  4  I byte strobes.
- i_wdata  in  DATA_W  I write data.
- i_addr_ok, i_data_ok  out  1 each  I handshake returns.
- i_rdata  out  DATA_W  I read data.
- d_req, d_wr, d_cached, d_size, d_addr, d_wstrb, d_wdata, d_addr_ok, d_data_ok, d_rdata  same widths and directions as i_*  D master.
- bus_req, bus_wr, bus_cached  out  1 each  downstream request.
- bus_size  out  2.
- bus_addr  out  ADDR_W.
- bus_wstrb  out  4.
- bus_wdata  out  DATA_W.
- bus_addr_ok, bus_data_ok  in  1 each  downstream handshake.
- bus_rdata  in  DATA_W  downstream read data.
- outstanding  out  $clog2(MAX_OUT)+1  accepted-unreturned count.
- arb_err  out  1  sticky: data_ok received with nothing outstanding.

Behaviour:
- Reset (async, rst=0): FIFO empty, outstanding=0, state=ARB, arb_err=0. All *_addr_ok, *_data_ok and bus_req are 0 while rst=0.
- Owner FIFO: MAX_OUT entries, 1-bit id (0=I, 1=D).
  - Push id on bus_req&&bus_addr_ok.
  - Pop on bus_data_ok when not empty.
  - Push and pop in the same cycle leave the count unchanged; pointers wrap modulo MAX_OUT.
- full = (outstanding==MAX_OUT). When full: bus_req=0 and both addr_ok=0, regardless of state.
- State machine:
  - ARB: grant D if d_req, else I if i_req (D has priority because it is the older instruction). If the granted master's request is not accepted this cycle (bus_addr_ok=0), go to LOCK_D or LOCK_I.
  - LOCK_x: grant only x, ignoring the other master's req. Return to ARB when bus_addr_ok=1, or when x_req falls (flushed master withdrew).
  - If x_req falls in LOCK_x, the cycle is a fresh ARB decision: the other master may win in that same cycle.
- Request mux: bus_* = granted master's fields. bus_req = granted x_req && !full. x_addr_ok = bus_addr_ok && granted==x && bus_req. Non-granted addr_ok is 0.
- Response routing (combinational, zero latency):
  - Steer bus_data_ok to the head id; both *_rdata = bus_rdata.
  - Empty-FIFO bypass: same-cycle bus_addr_ok&&bus_data_ok with FIFO empty steers to the current grant, and the FIFO is neither pushed nor popped.
  - bus_data_ok with FIFO empty and no accepting push this cycle: no data_ok is forwarded, and arb_err is set (cleared only by reset).
- D write and I read to the same address are accepted in grant order; no reordering ever.
- Reset mid-operation clears the FIFO. Late bus_data_ok after reset hits an empty FIFO and sets arb_err; the downstream is reset by the same rst, so this must not occur in-system.

Decomposition:
- Shared package (mem_arb_pkg): master-id enum {MST_I, MST_D}, arbiter-state enum {ARB, LOCK_I, LOCK_D}, size encodings (already in the global defines).
- One sub-module: arb_owner_fifo (1-bit wide, MAX_OUT deep, push/pop/full/empty/count).
- Expected RTL ~200 lines.

Test Plan:
- i_req=1 and d_req=1 simultaneously, bus_addr_ok=1 → d_addr_ok=1, i_addr_ok=0, FIFO head=D. Next cycle I is granted.
- i_req alone, bus_addr_ok=0 for 3 cycles, d_req rises in cycle 2 → bus_addr stays i_addr through the lock. I is accepted in cycle 4, then D is granted.
- Two accepts (I then D) with bus_data_ok withheld: outstanding=2, bus_req=0. A third d_req gets no addr_ok until the first data_ok, which pulses i_data_ok with i_rdata=bus_rdata.
- FIFO empty, d_req with bus_addr_ok=bus_data_ok=1 same cycle, rdata=32'hDEADBEEF → d_data_ok=1, d_rdata=32'hDEADBEEF, outstanding stays 0.
- LOCK_D entered, then d_req drops with i_req=1 and bus_addr_ok=1 → i_addr_ok=1 that cycle, state ARB.
- rst pulled low asynchronously mid-cycle with outstanding=1 → outputs clear immediately. After release, a stray bus_data_ok sets arb_err=1 and no *_data_ok is forwarded.
